// File: rtl/oreg_ctrl_pkg.sv
// Shared constants for the output-register layer sequencer: or_cs codes,
// per-layer window geometry and FSM state encodings.
package oreg_ctrl_pkg;

  localparam logic [5:0] CS_IDLE = 6'd0;
  localparam logic [5:0] CS_CFG  = 6'd2;
  localparam logic [5:0] CS_CAL  = 6'd4;
  localparam logic [5:0] CS_LEND = 6'd8;
  localparam logic [5:0] CS_DONE = 6'd16;

  localparam int TAB_LAYERS = 7;

  // Entry 0 sits in the least-significant slot.
  localparam logic [TAB_LAYERS-1:0][3:0] P_TAB =
    {4'd2, 4'd2, 4'd2, 4'd4, 4'd5, 4'd4, 4'd8};
  localparam logic [TAB_LAYERS-1:0][2:0] S_TAB =
    {3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd4};

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CFG  = 3'd1;
  localparam logic [2:0] ST_CAL  = 3'd2;
  localparam logic [2:0] ST_LEND = 3'd3;
  localparam logic [2:0] ST_ABRT = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  function automatic logic [3:0] win_p(input logic [2:0] idx);
    return (idx < 3'(TAB_LAYERS)) ? P_TAB[idx] : 4'd0;
  endfunction

  function automatic logic [2:0] win_s(input logic [2:0] idx);
    return (idx < 3'(TAB_LAYERS)) ? S_TAB[idx] : 3'd0;
  endfunction

  // ABRT shares the layer-end code so the register file resets its pointers.
  function automatic logic [5:0] cs_of(input logic [2:0] st);
    logic [5:0] cs;
    case (st)
      ST_CFG:  cs = CS_CFG;
      ST_CAL:  cs = CS_CAL;
      ST_LEND: cs = CS_LEND;
      ST_ABRT: cs = CS_LEND;
      ST_DONE: cs = CS_DONE;
      default: cs = CS_IDLE;
    endcase
    return cs;
  endfunction

endpackage

// File: rtl/oreg_layer_ctrl_win_cnt.sv
// Per-layer write/read progress tracking and stall watchdog for the
// output-register sequencer.
module oreg_win_cnt #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [3:0]       p,
  input  logic [2:0]       s,
  input  logic [CNT_W-1:0] n,
  input  logic             pe_vld,
  input  logic             oreg_vld,
  input  logic             dn_ready,
  output logic             wr_full,
  output logic             rd_done,
  output logic             overflow,
  output logic             timeout
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [CNT_W:0]   wr_cnt;
  logic [CNT_W:0]   rd_pos;
  logic [WD_W-1:0]  wd_cnt;

  assign wr_full  = (wr_cnt == {1'b0, n});
  assign rd_done  = ({1'b0, rd_pos} + (CNT_W+2)'(p)) > (CNT_W+2)'(n);
  assign overflow = enable && pe_vld && wr_full;
  assign timeout  = (wd_cnt == WD_W'(TIMEOUT));

  // Watchdog only advances while downstream is ready, so backpressure never aborts a layer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt <= '0;
      rd_pos <= '0;
      wd_cnt <= '0;
    end else if (clear) begin
      wr_cnt <= '0;
      rd_pos <= '0;
      wd_cnt <= '0;
    end else if (enable) begin
      if (pe_vld && !wr_full)
        wr_cnt <= wr_cnt + 1'b1;
      if (oreg_vld && !rd_done)
        rd_pos <= rd_pos + (CNT_W+1)'(s);
      if (pe_vld || oreg_vld)
        wd_cnt <= '0;
      else if (dn_ready && !timeout)
        wd_cnt <= wd_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/oreg_layer_ctrl.sv
// Layer sequencer for the PE-array output register file: walks the layer
// table, drives or_cs, and gates the PE array on downstream backpressure.
module oreg_layer_ctrl
  import oreg_ctrl_pkg::*;
#(
  parameter int NUM_LAYERS = 7,
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 1024,
  parameter int OR_CS_W    = 6
) (
  input  logic               clk_cal,
  input  logic               rst_cal,
  input  logic               start,
  input  logic               abort,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_layer,
  input  logic [CNT_W-1:0]   cfg_outcnt,
  input  logic               pe_odata_vld,
  input  logic               oreg_odata_vld,
  input  logic               dn_ready,
  output logic [OR_CS_W-1:0] or_cs,
  output logic [3:0]         P,
  output logic [2:0]         S,
  output logic [2:0]         layer_idx,
  output logic               pe_en,
  output logic               busy,
  output logic               layer_done,
  output logic               net_done,
  output logic               err
);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] n_tab [NUM_LAYERS];
  logic [CNT_W-1:0] n_cur;
  logic [CNT_W-1:0] n_sel;
  logic [3:0]       p_sel;
  logic [2:0]       s_sel;
  logic             short_layer;
  logic             last_layer;
  logic             wr_full;
  logic             rd_done;
  logic             overflow;
  logic             timeout;

  assign n_sel       = n_tab[layer_idx];
  assign p_sel       = win_p(layer_idx);
  assign s_sel       = win_s(layer_idx);
  assign short_layer = n_sel < CNT_W'(p_sel);
  assign last_layer  = (layer_idx == 3'(NUM_LAYERS - 1));

  always_ff @(posedge clk_cal or posedge rst_cal) begin
    if (rst_cal) begin
      for (int i = 0; i < NUM_LAYERS; i++)
        n_tab[i] <= '0;
    end else if (state == ST_IDLE && cfg_we && 32'(cfg_layer) < NUM_LAYERS) begin
      n_tab[cfg_layer] <= cfg_outcnt;
    end
  end

  // Abort overrides every other transition once a run is in flight.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_CFG;
      ST_CFG:  state_nxt = short_layer ? ST_LEND : ST_CAL;
      ST_CAL:  if ((wr_full && rd_done) || timeout) state_nxt = ST_LEND;
      ST_LEND: state_nxt = last_layer ? ST_DONE : ST_CFG;
      ST_ABRT: state_nxt = ST_IDLE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (abort && state != ST_IDLE)
      state_nxt = ST_ABRT;
  end

  // Status outputs are decoded from the next state so they line up with the registered state.
  always_ff @(posedge clk_cal or posedge rst_cal) begin
    if (rst_cal) begin
      state      <= ST_IDLE;
      or_cs      <= '0;
      P          <= '0;
      S          <= '0;
      n_cur      <= '0;
      layer_idx  <= '0;
      pe_en      <= 1'b0;
      busy       <= 1'b0;
      layer_done <= 1'b0;
      net_done   <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      or_cs      <= OR_CS_W'(cs_of(state_nxt));
      busy       <= (state_nxt != ST_IDLE);
      layer_done <= (state_nxt == ST_LEND);
      net_done   <= (state_nxt == ST_DONE);
      pe_en      <= (state_nxt == ST_CAL) && dn_ready;
      if (state == ST_IDLE && start) begin
        layer_idx <= '0;
        err       <= 1'b0;
      end
      if (state == ST_CFG) begin
        P     <= p_sel;
        S     <= s_sel;
        n_cur <= n_sel;
        if (short_layer)
          err <= 1'b1;
      end
      if (state == ST_CAL && (overflow || timeout))
        err <= 1'b1;
      if (state == ST_LEND && state_nxt == ST_CFG)
        layer_idx <= layer_idx + 1'b1;
    end
  end

  oreg_win_cnt #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_win_cnt (
    .clk      (clk_cal),
    .rst      (rst_cal),
    .clear    (state == ST_CFG),
    .enable   (state == ST_CAL),
    .p        (P),
    .s        (S),
    .n        (n_cur),
    .pe_vld   (pe_odata_vld),
    .oreg_vld (oreg_odata_vld),
    .dn_ready (dn_ready),
    .wr_full  (wr_full),
    .rd_done  (rd_done),
    .overflow (overflow),
    .timeout  (timeout)
  );

endmodule

// File: tb/tb_oreg_layer_ctrl.sv
// Directed bench for oreg_layer_ctrl; a scoreboard queue holds the expected
// layer index and error flag for every layer_done pulse.
module tb_oreg_layer_ctrl;

  localparam int NL = 7;
  localparam int CW = 16;
  localparam int TO = 1024;

  logic          clk_cal;
  logic          rst_cal;
  logic          start;
  logic          abort;
  logic          cfg_we;
  logic [2:0]    cfg_layer;
  logic [CW-1:0] cfg_outcnt;
  logic          pe_odata_vld;
  logic          oreg_odata_vld;
  logic          dn_ready;
  logic [5:0]    or_cs;
  logic [3:0]    P;
  logic [2:0]    S;
  logic [2:0]    layer_idx;
  logic          pe_en;
  logic          busy;
  logic          layer_done;
  logic          net_done;
  logic          err;

  typedef struct {
    int   idx;
    logic err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   net_done_seen = 0;
  int   tab_n [NL] = '{32, 16, 16, 16, 8, 8, 8};
  int   tab_p [NL] = '{8, 4, 5, 4, 2, 2, 2};
  int   tab_s [NL] = '{4, 2, 2, 2, 2, 2, 2};

  oreg_layer_ctrl #(
    .NUM_LAYERS (NL),
    .CNT_W      (CW),
    .TIMEOUT    (TO),
    .OR_CS_W    (6)
  ) dut (
    .clk_cal        (clk_cal),
    .rst_cal        (rst_cal),
    .start          (start),
    .abort          (abort),
    .cfg_we         (cfg_we),
    .cfg_layer      (cfg_layer),
    .cfg_outcnt     (cfg_outcnt),
    .pe_odata_vld   (pe_odata_vld),
    .oreg_odata_vld (oreg_odata_vld),
    .dn_ready       (dn_ready),
    .or_cs          (or_cs),
    .P              (P),
    .S              (S),
    .layer_idx      (layer_idx),
    .pe_en          (pe_en),
    .busy           (busy),
    .layer_done     (layer_done),
    .net_done       (net_done),
    .err            (err)
  );

  initial clk_cal = 1'b0;
  always #5 clk_cal = ~clk_cal;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_cal);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic pe, input logic rd, input int cycles);
    pe_odata_vld   = pe;
    oreg_odata_vld = rd;
    step(cycles);
    pe_odata_vld   = 1'b0;
    oreg_odata_vld = 1'b0;
  endtask

  function automatic int readsOf(input int i);
    return (tab_n[i] - tab_p[i]) / tab_s[i] + 1;
  endfunction

  task automatic pushExp(input int idx, input logic e);
    exp_t t;
    t.idx = idx;
    t.err = e;
    sb.push_back(t);
  endtask

  task automatic writeTable(input int idx, input int n);
    cfg_we     = 1'b1;
    cfg_layer  = 3'(idx);
    cfg_outcnt = CW'(n);
    step(1);
    cfg_we     = 1'b0;
  endtask

  // Enters from the CFG cycle of layer idx and leaves one cycle after LEND.
  task automatic runLayer(input int idx, input logic exp_err);
    checkOutput($sformatf("cfg_cs_L%0d", idx), or_cs, 2);
    checkOutput($sformatf("cfg_idx_L%0d", idx), layer_idx, idx);
    step(1);
    checkOutput($sformatf("cal_cs_L%0d", idx), or_cs, 4);
    checkOutput($sformatf("P_L%0d", idx), P, tab_p[idx]);
    checkOutput($sformatf("S_L%0d", idx), S, tab_s[idx]);
    pushExp(idx, exp_err);
    applyStimulus(1'b1, 1'b0, tab_n[idx]);
    applyStimulus(1'b0, 1'b1, readsOf(idx));
    checkOutput($sformatf("still_cal_L%0d", idx), or_cs, 4);
    step(1);
    checkOutput($sformatf("lend_cs_L%0d", idx), or_cs, 8);
    step(1);
  endtask

  always @(negedge clk_cal) begin
    if (!rst_cal) begin
      if (layer_done) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_layer_done", layer_done, 0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("sb_layer_idx", layer_idx, mon_e.idx);
          checkOutput("sb_err", err, mon_e.err);
        end
      end
      if (net_done)
        net_done_seen++;
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int c;
    rst_cal        = 1'b1;
    start          = 1'b0;
    abort          = 1'b0;
    cfg_we         = 1'b0;
    cfg_layer      = '0;
    cfg_outcnt     = '0;
    pe_odata_vld   = 1'b0;
    oreg_odata_vld = 1'b0;
    dn_ready       = 1'b1;
    step(3);
    checkOutput("rst_or_cs", or_cs, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_pe_en", pe_en, 0);
    checkOutput("rst_P", P, 0);
    checkOutput("rst_S", S, 0);
    checkOutput("rst_layer_idx", layer_idx, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_net_done", net_done, 0);
    rst_cal = 1'b0;
    step(1);

    for (int i = 0; i < NL; i++)
      writeTable(i, tab_n[i]);

    // Run 1: full network, layer 0 with a write overflow and a held read.
    start = 1'b1;
    step(1);
    start = 1'b0;
    checkOutput("r1_cfg_cs", or_cs, 2);
    checkOutput("r1_busy", busy, 1);
    checkOutput("r1_idx", layer_idx, 0);
    step(1);
    checkOutput("r1_cal_cs", or_cs, 4);
    checkOutput("r1_P0", P, 8);
    checkOutput("r1_S0", S, 4);
    checkOutput("r1_pe_en", pe_en, 1);
    pushExp(0, 1'b1);
    cfg_we     = 1'b1;
    cfg_layer  = 3'd5;
    cfg_outcnt = 16'd1;
    start      = 1'b1;
    applyStimulus(1'b1, 1'b0, 32);
    cfg_we = 1'b0;
    start  = 1'b0;
    checkOutput("r1_err_before_ovf", err, 0);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("r1_err_after_ovf", err, 1);
    applyStimulus(1'b0, 1'b1, 6);
    step(3);
    checkOutput("r1_hold_6_reads", or_cs, 4);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("r1_cal_after_7th", or_cs, 4);
    step(1);
    checkOutput("r1_lend_cs", or_cs, 8);
    checkOutput("r1_layer_done", layer_done, 1);
    step(1);
    for (int i = 1; i < NL; i++)
      runLayer(i, 1'b1);
    checkOutput("r1_done_cs", or_cs, 16);
    checkOutput("r1_net_done", net_done, 1);
    checkOutput("r1_done_busy", busy, 1);
    step(1);
    checkOutput("r1_idle_busy", busy, 0);
    checkOutput("r1_idle_cs", or_cs, 0);
    checkOutput("r1_net_done_pulses", net_done_seen, 1);

    // Run 2: short layer 0, backpressure then stall on layer 1, abort in layer 3.
    writeTable(0, 4);
    start = 1'b1;
    step(1);
    start = 1'b0;
    checkOutput("r2_err_cleared", err, 0);
    checkOutput("r2_cfg_cs", or_cs, 2);
    pushExp(0, 1'b1);
    step(1);
    checkOutput("r2_skip_lend", or_cs, 8);
    checkOutput("r2_skip_err", err, 1);
    step(1);
    checkOutput("r2_cfg1_cs", or_cs, 2);
    checkOutput("r2_cfg1_idx", layer_idx, 1);
    dn_ready = 1'b0;
    step(1);
    checkOutput("r2_cal1_cs", or_cs, 4);
    checkOutput("r2_bp_pe_en", pe_en, 0);
    step(1999);
    checkOutput("r2_bp_no_timeout", or_cs, 4);
    checkOutput("r2_bp_pe_en_late", pe_en, 0);
    pushExp(1, 1'b1);
    dn_ready = 1'b1;
    step(1);
    c = 1;
    checkOutput("r2_pe_en_resume", pe_en, 1);
    while (or_cs != 6'd8 && c < 1100) begin
      step(1);
      c++;
    end
    checkOutput("r2_timeout_cycles", c, 1025);
    checkOutput("r2_timeout_err", err, 1);
    step(1);
    runLayer(2, 1'b1);
    checkOutput("r2_cfg3_idx", layer_idx, 3);
    step(1);
    checkOutput("r2_cal3_cs", or_cs, 4);
    applyStimulus(1'b1, 1'b0, 5);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    checkOutput("r2_abrt_cs", or_cs, 8);
    checkOutput("r2_abrt_no_layer_done", layer_done, 0);
    checkOutput("r2_abrt_busy", busy, 1);
    checkOutput("r2_abrt_pe_en", pe_en, 0);
    step(1);
    checkOutput("r2_abrt_idle_cs", or_cs, 0);
    checkOutput("r2_abrt_idle_busy", busy, 0);

    // Run 3: restart after abort, then abort from CFG.
    start = 1'b1;
    step(1);
    start = 1'b0;
    checkOutput("r3_idx", layer_idx, 0);
    checkOutput("r3_err_cleared", err, 0);
    checkOutput("r3_cfg_cs", or_cs, 2);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    checkOutput("r3_abrt_cs", or_cs, 8);
    step(1);
    checkOutput("r3_idle_cs", or_cs, 0);

    step(2);
    checkOutput("sb_empty", sb.size(), 0);
    checkOutput("net_done_total", net_done_seen, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/oreg_layer_ctrl.md
Name: oreg_layer_ctrl

Overview:
Layer sequencer for the PE-array output register file. It steps the network through its conv/pool layers and presents each layer's window size P and stride S. It drives the or_cs state code the register file decodes (6'd4 = calculate, 6'd8 = layer end/pointer reset). It counts PE writes and windowed reads, gates the PE array on downstream backpressure, and flags malformed layers and stalls.

Parameters:
NUM_LAYERS, 7, number of layers sequenced per run
CNT_W, 16, width of per-layer output-count fields
TIMEOUT, 1024, idle cycles in CAL before stall abort
OR_CS_W, 6, width of or_cs code

Ports:
clk_cal  in  1  calculation clock
rst_cal  in  1  asynchronous reset, active-high
start  in  1  one-cycle run request; honoured only in IDLE
abort  in  1  synchronous abort request; honoured in any non-IDLE state
cfg_we  in  1  layer-table write strobe; honoured only in IDLE
cfg_layer  in  3  table index written
cfg_outcnt  in  CNT_W  N = PE outputs produced by that layer
pe_odata_vld  in  1  PE result written into the register file this cycle
oreg_odata_vld  in  1  register file emitted one window this cycle
dn_ready  in  1  downstream can accept windows
or_cs  out  OR_CS_W  state code to the register file
P  out  4  current window size
S  out  3  current stride
layer_idx  out  3  current layer
pe_en  out  1  PE array enable
busy  out  1  high in every state except IDLE
layer_done  out  1  one-cycle pulse per completed layer
net_done  out  1  one-cycle pulse at end of run
err  out  1  sticky error flag; cleared on accepted start

Behaviour:
- Reset: all outputs 0, state IDLE, table N entries 0. Table is writable only in IDLE; cfg_we elsewhere is ignored.
- P/S are fixed per layer from package constants: P = 8,4,5,4,2,2,2 and S = 4,2,2,2,2,2,2.
- States and or_cs codes: IDLE=0, CFG=2, CAL=4, LEND=8, ABRT=8, DONE=16. All outputs are registered.
- IDLE: on start → CFG, layer_idx←0, err←0. A start in any other state is ignored.
- CFG (1 cycle): latch P, S, N. Clear wr_cnt and rd_pos (CNT_W+1 bits).
  - If N<P: set err and go → LEND (skipped layer).
  - Otherwise → CAL.
- CAL:
  - pe_en = dn_ready.
  - Each pe_odata_vld: wr_cnt+1, saturating at N. A vld arriving at wr_cnt==N sets err and is dropped.
  - Each oreg_odata_vld: rd_pos += S.
  - Read completion: rd_done when rd_pos+P > N. Expected reads = floor((N−P)/S)+1.
  - When wr_cnt==N and rd_done are both true → LEND. If both become true in the same cycle as a final vld, the transition occurs on the next edge.
  - Stall watchdog counts cycles with no pe_odata_vld and no oreg_odata_vld while dn_ready=1. When it reaches TIMEOUT → set err, go to LEND.
- LEND (1 cycle, or_cs=8): layer_done=1.
  - If layer_idx==NUM_LAYERS−1 → DONE.
  - Otherwise layer_idx+1 → CFG.
- DONE (1 cycle): net_done=1 → IDLE.
- abort: any non-IDLE state → ABRT. ABRT is 1 cycle with or_cs=8 so the register file resets its pointers, and produces no layer_done. Then → IDLE. Abort has priority over all other transitions.
- pe_en is 0 outside CAL.
- Reset mid-run returns to IDLE immediately; table contents are reset to 0.

Decomposition:
- Package oreg_ctrl_pkg holds:
  - or_cs codes: CS_IDLE, CS_CFG, CS_CAL, CS_LEND, CS_DONE
  - P_TAB and S_TAB constant arrays
  - state enum
- One sub-module, oreg_win_cnt, contains wr_cnt, rd_pos, rd_done compare and watchdog. It has clear, enable and P/S/N inputs.

Test Plan:
- Table N={32,16,16,16,8,8,8}. Start; on layer 0 issue 32 writes and 7 reads → LEND (or_cs=8) one cycle after the last event, layer_done, P=4/S=2 in CFG. After layer 6 → net_done, busy=0.
- Layer 0 with only 6 reads after 32 writes → stays CAL. The 7th read → LEND.
- N=4 on layer 0 (P=8) → err=1, CFG→LEND directly, no CAL cycle, sequencing continues to layer 1.
- 33rd pe_odata_vld in layer 0 → err=1, wr_cnt stays 32, completion unaffected.
- dn_ready=0 for 2000 cycles in CAL → pe_en=0, no timeout. dn_ready=1 with no activity for 1024 cycles → err=1, LEND.
- abort in CAL of layer 3 → next cycle or_cs=8, no layer_done, then IDLE. start afterwards → layer_idx=0, err cleared.
